// File: rtl/pr_scoreboard_if.sv
// Bundle of the pr_scoreboard control, dispatch, wakeup and status signals.
// PR_SCOREBOARD_CKPT_EN adds the checkpoint save/restore strobes.
interface pr_scoreboard_if #(
  parameter int PR_NUM = 64,
  parameter int PR_W   = 6,
  parameter int DISP_W = 4,
  parameter int WB_W   = 4,
  parameter int LAT_W  = 3
);
  localparam int CNT_W = $clog2(PR_NUM + 1);

  logic                    flush;
  logic [DISP_W-1:0]       disp_en;
  logic [DISP_W*PR_W-1:0]  disp_pr;
  logic [WB_W-1:0]         wb_en;
  logic [WB_W*PR_W-1:0]    wb_pr;
  logic [WB_W*LAT_W-1:0]   wb_lat;
  logic [PR_NUM-1:0]       pr_ready;
  logic [CNT_W-1:0]        busy_cnt;
`ifdef PR_SCOREBOARD_CKPT_EN
  logic                    ckpt_save;
  logic                    ckpt_restore;
`endif

  modport master (
    output flush, disp_en, disp_pr, wb_en, wb_pr, wb_lat,
`ifdef PR_SCOREBOARD_CKPT_EN
    output ckpt_save, ckpt_restore,
`endif
    input  pr_ready, busy_cnt
  );

  modport slave (
    input  flush, disp_en, disp_pr, wb_en, wb_pr, wb_lat,
`ifdef PR_SCOREBOARD_CKPT_EN
    input  ckpt_save, ckpt_restore,
`endif
    output pr_ready, busy_cnt
  );
endinterface

// File: rtl/pr_scoreboard.sv
// Physical-register ready scoreboard with delayed wakeup timers.
// Each PR has a ready bit, a pending flag and a down-counter; a delayed
// wakeup sets the ready bit L+1 edges after it is sampled.
// Optional feature: define PR_SCOREBOARD_CKPT_EN for a ready-bit snapshot
// with save/restore strobes.
module pr_scoreboard #(
  parameter int PR_NUM = 64,
  parameter int PR_W   = 6,
  parameter int DISP_W = 4,
  parameter int WB_W   = 4,
  parameter int LAT_W  = 3
) (
  input logic             clk,
  input logic             rst,
  pr_scoreboard_if.slave  sb
);
  localparam int CNT_W = $clog2(PR_NUM + 1);

  logic [PR_NUM-1:0] ready_q, ready_d, ready_nrm;
  logic [PR_NUM-1:0] pend_q, pend_d;
  logic [LAT_W-1:0]  cnt_q [PR_NUM];
  logic [LAT_W-1:0]  cnt_d [PR_NUM];
  logic [CNT_W-1:0]  busy_q, busy_d;

  logic [PR_NUM-1:0] disp_hit;
  logic [PR_NUM-1:0] wb_hit;
  logic [LAT_W-1:0]  wb_lat_sel [PR_NUM];
  logic [PR_NUM-1:0] wb_now;
  logic [PR_NUM-1:0] wb_load;
  logic [PR_NUM-1:0] expire;

  // Decode dispatch ports into a per-PR clear mask; duplicates simply OR.
  always_comb begin
    disp_hit = '0;
    for (int i = 0; i < DISP_W; i++) begin
      if (sb.disp_en[i]) disp_hit[sb.disp_pr[i*PR_W +: PR_W]] = 1'b1;
    end
  end

  // Decode wakeup ports; scanning high to low lets the lowest port's delay win.
  always_comb begin
    wb_hit = '0;
    for (int p = 0; p < PR_NUM; p++) wb_lat_sel[p] = '0;
    for (int i = WB_W - 1; i >= 0; i--) begin
      if (sb.wb_en[i]) begin
        wb_hit[sb.wb_pr[i*PR_W +: PR_W]]     = 1'b1;
        wb_lat_sel[sb.wb_pr[i*PR_W +: PR_W]] = sb.wb_lat[i*LAT_W +: LAT_W];
      end
    end
  end

  // Classify per-PR events: immediate wakeup, timer load, timer expiry.
  always_comb begin
    wb_now  = '0;
    wb_load = '0;
    expire  = '0;
    for (int p = 0; p < PR_NUM; p++) begin
      wb_now[p]  = wb_hit[p] && (wb_lat_sel[p] == '0);
      wb_load[p] = wb_hit[p] && (wb_lat_sel[p] != '0);
      expire[p]  = pend_q[p] && (cnt_q[p] == '0);
    end
  end

  // Per-PR next state: flush, then set events, then dispatch clear.
  always_comb begin
    ready_nrm = ready_q;
    pend_d    = pend_q;
    for (int p = 0; p < PR_NUM; p++) cnt_d[p] = cnt_q[p];
    if (sb.flush) begin
      ready_nrm = '1;
      pend_d    = '0;
      for (int p = 0; p < PR_NUM; p++) cnt_d[p] = '0;
    end else begin
      for (int p = 0; p < PR_NUM; p++) begin
        if (wb_now[p] || expire[p]) ready_nrm[p] = 1'b1;
        else if (disp_hit[p])       ready_nrm[p] = 1'b0;

        // A fresh delayed wakeup (re)arms the timer even over a same-cycle
        // dispatch; an expiring timer is not cancelled, it just completes.
        if (wb_load[p]) begin
          pend_d[p] = 1'b1;
          cnt_d[p]  = wb_lat_sel[p];
        end else if (wb_now[p] || expire[p] || disp_hit[p]) begin
          pend_d[p] = 1'b0;
          cnt_d[p]  = '0;
        end else if (pend_q[p]) begin
          cnt_d[p]  = cnt_q[p] - LAT_W'(1);
        end
      end
    end
  end

`ifdef PR_SCOREBOARD_CKPT_EN
  logic [PR_NUM-1:0] snap_q, snap_d;

  // Restore ORs the snapshot into the ready bits; save captures post-update bits.
  always_comb begin
    ready_d = ready_nrm;
    snap_d  = snap_q;
    if (!sb.flush) begin
      if (sb.ckpt_restore)   ready_d = snap_q | ready_nrm;
      else if (sb.ckpt_save) snap_d  = ready_nrm;
    end
  end

  // Snapshot register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) snap_q <= '1;
    else     snap_q <= snap_d;
  end
`else
  assign ready_d = ready_nrm;
`endif

  // Busy count is computed from the next ready bits so it tracks the same edge.
  always_comb begin
    busy_d = '0;
    for (int p = 0; p < PR_NUM; p++) busy_d = busy_d + CNT_W'(!ready_d[p]);
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= '1;
      pend_q  <= '0;
      busy_q  <= '0;
      for (int p = 0; p < PR_NUM; p++) cnt_q[p] <= '0;
    end else begin
      ready_q <= ready_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      for (int p = 0; p < PR_NUM; p++) cnt_q[p] <= cnt_d[p];
    end
  end

  assign sb.pr_ready = ready_q;
  assign sb.busy_cnt = busy_q;
endmodule

// File: tb/tb_pr_scoreboard.sv
// Directed bench for pr_scoreboard with default parameters.
module tb_pr_scoreboard;
  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  pr_scoreboard_if #(.PR_NUM(64), .PR_W(6), .DISP_W(4), .WB_W(4), .LAT_W(3)) sb_if ();

  pr_scoreboard #(.PR_NUM(64), .PR_W(6), .DISP_W(4), .WB_W(4), .LAT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    sb_if.flush   = 1'b0;
    sb_if.disp_en = '0;
    sb_if.disp_pr = '0;
    sb_if.wb_en   = '0;
    sb_if.wb_pr   = '0;
    sb_if.wb_lat  = '0;
`ifdef PR_SCOREBOARD_CKPT_EN
    sb_if.ckpt_save    = 1'b0;
    sb_if.ckpt_restore = 1'b0;
`endif
  endtask

  task automatic disp(input int port, input int pr);
    logic [5:0] prv;
    prv = 6'(pr);
    sb_if.disp_en[port]       = 1'b1;
    sb_if.disp_pr[port*6 +: 6] = prv;
  endtask

  task automatic wake(input int port, input int pr, input int lat);
    logic [5:0] prv;
    logic [2:0] latv;
    prv  = 6'(pr);
    latv = 3'(lat);
    sb_if.wb_en[port]          = 1'b1;
    sb_if.wb_pr[port*6 +: 6]   = prv;
    sb_if.wb_lat[port*3 +: 3]  = latv;
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    idle();
    #3;
    chk("rst_ready", sb_if.pr_ready, {64{1'b1}});
    chk("rst_busy", 64'(sb_if.busy_cnt), 64'd0);
    step();
    step();
    rst = 1'b0;

    // Dispatch PR5 and PR63.
    disp(0, 5); disp(1, 63);
    step(); idle();
    chk("d_r5", 64'(sb_if.pr_ready[5]), 64'd0);
    chk("d_r63", 64'(sb_if.pr_ready[63]), 64'd0);
    chk("d_busy", 64'(sb_if.busy_cnt), 64'd2);

    // Dispatch PR9, then wakeup with L=3: set at the 4th edge after sampling.
    disp(0, 9);
    step(); idle();
    chk("w9_busy0", 64'(sb_if.busy_cnt), 64'd3);
    wake(0, 9, 3);
    step(); idle();
    chk("w9_e0", 64'(sb_if.pr_ready[9]), 64'd0);
    step(); chk("w9_e1", 64'(sb_if.pr_ready[9]), 64'd0);
    step(); chk("w9_e2", 64'(sb_if.pr_ready[9]), 64'd0);
    step(); chk("w9_e3", 64'(sb_if.pr_ready[9]), 64'd0);
    step(); chk("w9_e4", 64'(sb_if.pr_ready[9]), 64'd1);
    chk("w9_busy", 64'(sb_if.busy_cnt), 64'd2);

    // Same-cycle dispatch and L=0 wakeup: set wins.
    disp(0, 12); wake(2, 12, 0);
    step(); idle();
    chk("r12_set", 64'(sb_if.pr_ready[12]), 64'd1);
    chk("r12_busy", 64'(sb_if.busy_cnt), 64'd2);

    // Duplicate dispatch counts as one clear.
    disp(0, 30); disp(1, 30); disp(2, 30);
    step(); idle();
    chk("dup_busy", 64'(sb_if.busy_cnt), 64'd3);

    // Dispatch cancels a timer that is not yet expiring.
    wake(0, 30, 1);
    step(); idle();
    disp(3, 30);
    step(); idle();
    step(); chk("cancel_a", 64'(sb_if.pr_ready[30]), 64'd0);
    step(); chk("cancel_b", 64'(sb_if.pr_ready[30]), 64'd0);

    // Expiry in the same cycle as a dispatch wins.
    wake(0, 30, 1);
    step(); idle();
    step();
    disp(0, 30);
    step(); idle();
    chk("exp_win", 64'(sb_if.pr_ready[30]), 64'd1);
    chk("exp_busy", 64'(sb_if.busy_cnt), 64'd2);

    // Lowest wakeup port supplies the delay: L=2 -> set 3 edges later.
    disp(0, 20);
    step(); idle();
    wake(1, 20, 2); wake(3, 20, 5);
    step(); idle();
    chk("lo_e0", 64'(sb_if.pr_ready[20]), 64'd0);
    step(); chk("lo_e1", 64'(sb_if.pr_ready[20]), 64'd0);
    step(); chk("lo_e2", 64'(sb_if.pr_ready[20]), 64'd0);
    step(); chk("lo_e3", 64'(sb_if.pr_ready[20]), 64'd1);

    // Reload of a pending timer: L=5 then L=1 one cycle later.
    disp(0, 40);
    step(); idle();
    wake(0, 40, 5);
    step(); idle();
    wake(2, 40, 1);
    step(); idle();
    step(); chk("rl_a", 64'(sb_if.pr_ready[40]), 64'd0);
    step(); chk("rl_b", 64'(sb_if.pr_ready[40]), 64'd1);

    // Wakeup to a ready PR leaves it ready.
    wake(0, 50, 0);
    step(); idle();
    chk("rdy_keep", 64'(sb_if.pr_ready[50]), 64'd1);
    chk("rdy_busy", 64'(sb_if.busy_cnt), 64'd2);

    // Dispatch 8 PRs, arm two timers, then flush with ignored inputs.
    disp(0, 0); disp(1, 1); disp(2, 2); disp(3, 3);
    step(); idle();
    disp(0, 6); disp(1, 7); disp(2, 8); disp(3, 10);
    step(); idle();
    chk("f8_busy", 64'(sb_if.busy_cnt), 64'd10);
    wake(0, 0, 4); wake(1, 1, 6);
    step(); idle();
    sb_if.flush = 1'b1;
    disp(0, 11);
    step(); idle();
    chk("fl_ready", sb_if.pr_ready, {64{1'b1}});
    chk("fl_busy", 64'(sb_if.busy_cnt), 64'd0);
    disp(0, 0); disp(1, 1);
    step(); idle();
    for (int k = 0; k < 8; k++) step();
    chk("fl_nowake", sb_if.pr_ready[1:0], 64'd0);
    chk("fl_busy2", 64'(sb_if.busy_cnt), 64'd2);
    sb_if.flush = 1'b1;
    step(); idle();

    // Reset in mid-countdown discards the timer.
    disp(0, 33);
    step(); idle();
    wake(0, 33, 3);
    step(); idle();
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_ready", sb_if.pr_ready, {64{1'b1}});
    chk("mrst_busy", 64'(sb_if.busy_cnt), 64'd0);
    #1;
    rst = 1'b0;
    disp(0, 33);
    step(); idle();
    for (int k = 0; k < 6; k++) step();
    chk("mrst_nowake", 64'(sb_if.pr_ready[33]), 64'd0);
    chk("mrst_busy2", 64'(sb_if.busy_cnt), 64'd1);
    sb_if.flush = 1'b1;
    step(); idle();

`ifdef PR_SCOREBOARD_CKPT_EN
    // Save with PR3 busy, dispatch PR4, restore.
    disp(0, 3);
    step(); idle();
    sb_if.ckpt_save = 1'b1;
    step(); idle();
    disp(0, 4);
    step(); idle();
    chk("ck_r4a", 64'(sb_if.pr_ready[4]), 64'd0);
    sb_if.ckpt_restore = 1'b1;
    step(); idle();
    chk("ck_r4", 64'(sb_if.pr_ready[4]), 64'd1);
    chk("ck_r3", 64'(sb_if.pr_ready[3]), 64'd0);
    chk("ck_busy", 64'(sb_if.busy_cnt), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
